simeck_round_ctrl: RTL and testbench
====================================

SIMECK_ROUND_CTRL -- requirements
Module: simeck_round_ctrl

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 32, giving the number of round iterations per block (legal range 1..63).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit, a request block is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit, the block can accept a request this cycle.
REQ-006 The block SHALL have port mode, input, 1 bit, 0 = encrypt, 1 = decrypt; sampled only at accept.
REQ-007 The block SHALL have port din, input, 32 bits: din[31:16] = left word L, din[15:0] = right word R.
REQ-008 The block SHALL have port key, input, 16 bits, round key used for every round; sampled only at accept.
REQ-009 The block SHALL have port out_valid, output, 1 bit, dout holds a finished result.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the consumer takes the result.
REQ-011 The block SHALL have port dout, output, 32 bits, the result with the same L/R packing as din.
REQ-012 The block SHALL have port busy, output, 1 bit, high in RUN state.

Function
REQ-013 The round function SHALL be f(x) = (x AND rotl(x,5)) XOR rotl(x,1) on 16-bit x.
REQ-014 An encrypt round SHALL compute L' = R ^ f(L) ^ k and R' = L.
REQ-015 A decrypt round SHALL compute L' = R and R' = L ^ f(R) ^ k, the exact inverse of REQ-014.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in RUN.
REQ-018 On in_valid && in_ready at edge T: the state register SHALL load din, key and mode SHALL latch, the round counter SHALL clear to 0, and the FSM SHALL go to RUN.
REQ-019 Each RUN cycle SHALL apply exactly one round to the state register and increment the counter.
REQ-020 When the counter reaches ROUNDS-1, the FSM SHALL go to DONE on that edge, so out_valid first rises ROUNDS cycles after edge T.
REQ-021 In DONE, dout SHALL hold stable and the FSM SHALL stay in DONE until out_ready is 1.
REQ-022 When out_valid && out_ready, the FSM SHALL go to IDLE at that edge, and in_ready SHALL be 1 the following cycle.
REQ-023 No new request SHALL be accepted in the same cycle as the output handshake.
REQ-024 Changes to din, key, mode or in_valid during RUN or DONE SHALL have no effect on the block.
REQ-025 Throughput SHALL be one block per ROUNDS+2 cycles when out_ready is held at 1.
REQ-026 dout SHALL be the state register directly, registered with no combinational path from din.

Reset
REQ-027 When rst_n is 0, the FSM SHALL go to IDLE, the counter, state register and latched key/mode SHALL go to 0, and the outputs SHALL be in_ready=1, out_valid=0, busy=0, dout=0x00000000.
REQ-028 A reset during RUN or DONE SHALL abort the block with no output handshake; the first accept after rst_n deasserts SHALL behave per REQ-018.

Structure
REQ-029 The shared package simeck_pkg SHALL hold: the FSM state enum, localparams for word width 16 and rotation amounts 5 and 1, and the mode encodings ENC=0 / DEC=1.
REQ-030 The block SHALL instantiate one combinational sub-module, simeck_round, with inputs state[31:0], key[15:0] and mode and output next[31:0]; the controller SHALL time-share this single instance across all rounds.

Verification
REQ-031 Reset: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, busy=0, dout=0x00000000.
REQ-032 ROUNDS=1, encrypt din=0x00000000, key=0x1234 -> out_valid 1 cycle after accept, dout=0x12340000.
REQ-033 ROUNDS=2, encrypt din=0x00000000, key=0x1234 -> dout=0x345C1234; then decrypt din=0x345C1234, key=0x1234 -> dout=0x00000000.
REQ-034 ROUNDS=32, 100 random din/key pairs -> decrypt(encrypt(x)) == x; out_valid exactly 32 cycles after each accept.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling din/key -> dout stable, in_ready=0; release -> IDLE next cycle.
REQ-036 Pull rst_n low at counter=15 in RUN -> IDLE immediately, no out_valid pulse; the next request completes correctly.

Source files
------------

// File: rtl/simeck_pkg.sv
// Shared types and constants for the Simeck-style round controller.
package simeck_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int   WORD_W   = 16;
   localparam int   ROT_A    = 5;
   localparam int   ROT_B    = 1;
   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int n);
      return (x << n) | (x >> (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] round_f(input logic [WORD_W-1:0] x);
      return (x & rotl(x, ROT_A)) ^ rotl(x, ROT_B);
   endfunction

endpackage

// File: rtl/simeck_round.sv
// One combinational Feistel round; decrypt is the exact inverse of encrypt.
module simeck_round
   import simeck_pkg::*;
(
   input  logic [31:0] state,
   input  logic [15:0] key,
   input  logic        mode,
   output logic [31:0] next
);

   logic [WORD_W-1:0] l_w;
   logic [WORD_W-1:0] r_w;

   assign l_w = state[31:16];
   assign r_w = state[15:0];

   always_comb begin
      next = state;
      if (mode == MODE_ENC) begin
         next = {r_w ^ round_f(l_w) ^ key, l_w};
      end else begin
         next = {r_w, l_w ^ round_f(r_w) ^ key};
      end
   end

endmodule

// File: rtl/simeck_round_ctrl.sv
// Iterative round controller: accepts a block, runs ROUNDS rounds through a
// single shared round instance, then holds the result until consumed.
module simeck_round_ctrl
   import simeck_pkg::*;
#(
   parameter int ROUNDS = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode,
   input  logic [31:0] din,
   input  logic [15:0] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] dout,
   output logic        busy,
   output logic [1:0]  dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // in_ready depends only on state (IDLE), out_valid only on state (DONE).

   localparam logic [5:0] LAST_CNT = 6'(ROUNDS - 1);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] blk_q, blk_d;
   logic [15:0] key_q, key_d;
   logic        mode_q, mode_d;
   logic [31:0] round_next_w;

   simeck_round u_round (
      .state (blk_q),
      .key   (key_q),
      .mode  (mode_q),
      .next  (round_next_w)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      key_d   = key_q;
      mode_d  = mode_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               blk_d   = din;
               key_d   = key;
               mode_d  = mode;
               cnt_d   = 6'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            blk_d = round_next_w;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Returning to IDLE first keeps an output handshake and a new
            // accept from ever sharing a cycle.
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 6'd0;
         blk_q   <= 32'd0;
         key_q   <= 16'd0;
         mode_q  <= MODE_ENC;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         key_q   <= key_d;
         mode_q  <= mode_d;
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign out_valid   = (state_q == ST_DONE);
   assign busy        = (state_q == ST_RUN);
   assign dout        = blk_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_simeck_round_ctrl.sv
// Directed bench for simeck_round_ctrl with ROUNDS = 1, 2 and 32 instances.
module tb_simeck_round_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] din;
   logic [15:0] key;
   logic        mode;
   logic        out_ready;
   logic [2:0]  iv;
   logic [2:0]  ir;
   logic [2:0]  ov;
   logic [2:0]  bz;
   logic [31:0] dout_w [3];
   logic [1:0]  st_w [3];

   int compared   = 0;
   int mismatched = 0;

   simeck_round_ctrl #(.ROUNDS(1)) u_r1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .mode(mode),
      .din(din), .key(key), .out_valid(ov[0]), .out_ready(out_ready),
      .dout(dout_w[0]), .busy(bz[0]), .dbg_state_o(st_w[0])
   );

   simeck_round_ctrl #(.ROUNDS(2)) u_r2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .mode(mode),
      .din(din), .key(key), .out_valid(ov[1]), .out_ready(out_ready),
      .dout(dout_w[1]), .busy(bz[1]), .dbg_state_o(st_w[1])
   );

   simeck_round_ctrl #(.ROUNDS(32)) u_r32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .mode(mode),
      .din(din), .key(key), .out_valid(ov[2]), .out_ready(out_ready),
      .dout(dout_w[2]), .busy(bz[2]), .dbg_state_o(st_w[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input int u, input string tag);
      check({tag, "_in_ready"},  32'(ir[u]), 32'd1);
      check({tag, "_out_valid"}, 32'(ov[u]), 32'd0);
      check({tag, "_busy"},      32'(bz[u]), 32'd0);
   endtask

   // Accept one block on instance u, wait (bounded) for out_valid, and
   // complete the output handshake if out_ready is currently high.
   task automatic run_block(input int u, input logic m, input logic [31:0] d,
                            input logic [15:0] k, input int exp_lat,
                            output logic [31:0] res);
      int lat;
      check("pre_accept_in_ready", 32'(ir[u]), 32'd1);
      mode  = m;
      din   = d;
      key   = k;
      iv[u] = 1'b1;
      @(posedge clk); #1;
      iv[u] = 1'b0;
      din   = $urandom;
      key   = 16'($urandom_range(0, 65535));
      mode  = 1'($urandom_range(0, 1));
      lat   = 0;
      while (!ov[u] && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      res = dout_w[u];
      if (out_ready) begin
         @(posedge clk); #1;
         check_idle_outputs(u, "post_handshake");
      end
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] ct;
      logic [31:0] pt;
      logic [15:0] k;

      rst_n     = 1'b0;
      iv        = 3'b000;
      out_ready = 1'b1;
      din       = 32'd0;
      key       = 16'd0;
      mode      = 1'b0;

      // Reset held with random inputs.
      for (int c = 0; c < 3; c++) begin
         din       = $urandom;
         key       = 16'($urandom_range(0, 65535));
         mode      = 1'($urandom_range(0, 1));
         iv        = 3'($urandom_range(0, 7));
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         for (int u = 0; u < 3; u++) begin
            check_idle_outputs(u, "reset");
            check("reset_dout",  dout_w[u],      32'h0000_0000);
            check("reset_state", 32'(st_w[u]),   32'd0);
         end
      end
      iv        = 3'b000;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      @(posedge clk); #1;

      // ROUNDS=1 encrypt and decrypt.
      run_block(0, 1'b0, 32'h0000_0000, 16'h1234, 1, res);
      check("r1_enc_dout", res, 32'h1234_0000);
      run_block(0, 1'b1, 32'h1234_0000, 16'h1234, 1, res);
      check("r1_dec_dout", res, 32'h0000_0000);

      // ROUNDS=2 encrypt then decrypt back.
      run_block(1, 1'b0, 32'h0000_0000, 16'h1234, 2, res);
      check("r2_enc_dout", res, 32'h345C_1234);
      run_block(1, 1'b1, 32'h345C_1234, 16'h1234, 2, res);
      check("r2_dec_dout", res, 32'h0000_0000);

      // Backpressure in DONE with inputs toggling.
      out_ready = 1'b0;
      run_block(1, 1'b0, 32'h0000_0000, 16'h1234, 2, res);
      check("bp_first_dout", res, 32'h345C_1234);
      for (int c = 0; c < 10; c++) begin
         din   = $urandom;
         key   = 16'($urandom_range(0, 65535));
         mode  = 1'($urandom_range(0, 1));
         iv[1] = 1'b1;
         @(posedge clk); #1;
         check("bp_dout_stable", dout_w[1], 32'h345C_1234);
         check("bp_in_ready",    32'(ir[1]), 32'd0);
         check("bp_out_valid",   32'(ov[1]), 32'd1);
      end
      // Release with in_valid still high: handshake edge must not also accept.
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs(1, "bp_release");
      iv[1] = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs(1, "bp_release_hold");

      // ROUNDS=32 round trips on random data.
      for (int n = 0; n < 100; n++) begin
         pt = $urandom;
         k  = 16'($urandom_range(0, 65535));
         run_block(2, 1'b0, pt, k, 32, ct);
         run_block(2, 1'b1, ct, k, 32, res);
         check("r32_roundtrip", res, pt);
      end

      // Reset in the middle of RUN (counter = 15).
      din   = 32'hDEAD_BEEF;
      key   = 16'hBEEF;
      mode  = 1'b0;
      iv[2] = 1'b1;
      @(posedge clk); #1;
      iv[2] = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("midrun_busy", 32'(bz[2]), 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs(2, "midrun_reset");
      check("midrun_reset_dout",  dout_w[2],    32'h0000_0000);
      check("midrun_reset_state", 32'(st_w[2]), 32'd0);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         check("midrun_no_valid", 32'(ov[2]), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_block(2, 1'b0, 32'hDEAD_BEEF, 16'hBEEF, 32, ct);
      run_block(2, 1'b1, ct, 16'hBEEF, 32, res);
      check("after_reset_roundtrip", res, 32'hDEAD_BEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
